and_share_sched: RTL and testbench

Round-robin scheduler that shares one two-stage registered AND datapath among `NUM_REQ` requesters. Each requester offers an operand pair (x, y) with a valid/ready handshake. The scheduler grants at most one requester per cycle and pushes the winning pair into the pipeline. It returns the tagged result two cycles later. It sits beside the pd0 AND probes as the first shared-resource controller in the processor bring-up path.

---
 rtl/and_sched_pkg.sv | 26 ++
 rtl/and_pipe2.sv | 65 ++++++
 rtl/and_share_sched.sv | 100 ++++++++++
 tb/tb_and_share_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/and_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : and_sched_pkg
// Purpose  : Shared constants, tag-width helper and response type for the
//            shared AND datapath scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package and_sched_pkg;

  localparam int MAX_REQ   = 8;
  localparam int GCOUNT_W  = 16;
  localparam int MAX_ID_W  = 3;
  localparam int MAX_WIDTH = 64;

  // Tag width for n requesters; a single requester still carries a 1-bit tag.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [MAX_ID_W-1:0]  id;
    logic [MAX_WIDTH-1:0] z;
  } rsp_t;

endpackage : and_sched_pkg
`default_nettype wire

// File: rtl/and_pipe2.sv
`default_nettype none
// ============================================================================
// Module   : and_pipe2
// Purpose  : Two-stage registered AND with a valid/tag sideband.
// Revision : 1.0 - initial release
// ============================================================================
module and_pipe2 #(
  parameter int WIDTH = 32,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [ID_W-1:0]  i_id,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_valid,
  output logic [ID_W-1:0]  o_id,
  output logic [WIDTH-1:0] o_z
);

  logic             r_s1_valid;
  logic [ID_W-1:0]  r_s1_id;
  logic [WIDTH-1:0] r_s1_x;
  logic [WIDTH-1:0] r_s1_y;

  logic             r_s2_valid;
  logic [ID_W-1:0]  r_s2_id;
  logic [WIDTH-1:0] r_s2_z;

  // Stage 1 holds its operands between accepts; only the valid bit pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
    end else begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_id <= i_id;
        r_s1_x  <= i_x;
        r_s1_y  <= i_y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
      r_s2_z     <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_id    <= r_s1_id;
      r_s2_z     <= r_s1_x & r_s1_y;
    end
  end

  assign o_valid = r_s2_valid;
  assign o_id    = r_s2_id;
  assign o_z     = r_s2_z;

endmodule : and_pipe2
`default_nettype wire

// File: rtl/and_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : and_share_sched
// Purpose  : Round-robin scheduler sharing one two-stage AND pipeline among
//            NUM_REQ valid/ready requesters; returns tagged results.
// Revision : 1.0 - initial release
// ============================================================================
module and_share_sched
  import and_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_z,
  output logic [GCOUNT_W-1:0]      grant_count
);

  logic [ID_W-1:0]     r_ptr;
  logic [GCOUNT_W-1:0] r_grant_count;

  logic                w_found;
  logic [ID_W-1:0]     w_winner;
  logic                w_grant_en;
  logic                w_accept;
  logic [ID_W-1:0]     w_ptr_next;
  logic [WIDTH-1:0]    w_x;
  logic [WIDTH-1:0]    w_y;
  int                  w_idx;

  // Scan from the pointer upward, wrapping at NUM_REQ so unused tags never win.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(w_idx);
      end
    end
  end

  // Ready is forced low during reset so nothing transfers into a clearing pipe.
  assign w_grant_en = enable & w_found & ~reset;

  always_comb begin
    req_ready = '0;
    if (w_grant_en) begin
      req_ready[w_winner] = 1'b1;
    end
  end

  assign w_accept   = |(req_valid & req_ready);
  assign w_ptr_next = (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + ID_W'(1);
  assign w_x        = req_x[int'(w_winner)*WIDTH +: WIDTH];
  assign w_y        = req_y[int'(w_winner)*WIDTH +: WIDTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr         <= '0;
      r_grant_count <= '0;
    end else if (w_accept) begin
      r_ptr         <= w_ptr_next;
      r_grant_count <= r_grant_count + GCOUNT_W'(1);
    end
  end

  assign grant_count = r_grant_count;

  and_pipe2 #(
    .WIDTH (WIDTH),
    .ID_W  (ID_W)
  ) u_pipe (
    .clk     (clock),
    .rst     (reset),
    .i_valid (w_accept),
    .i_id    (w_winner),
    .i_x     (w_x),
    .i_y     (w_y),
    .o_valid (rsp_valid),
    .o_id    (rsp_id),
    .o_z     (rsp_z)
  );

endmodule : and_share_sched
`default_nettype wire

// File: tb/tb_and_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_and_share_sched
// Purpose  : Directed scoreboard bench for and_share_sched (4 requesters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_and_share_sched;

  localparam int NR = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            enable = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*W-1:0] req_x = '0;
  logic [NR*W-1:0] req_y = '0;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_z;
  logic [15:0]     grant_count;

  and_share_sched #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clock       (clk),
    .reset       (rst),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_z       (rsp_z),
    .grant_count (grant_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [1:0] id;
    logic [31:0] z;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] x_op [NR];
  logic [31:0] y_op [NR];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NR; i++) begin
      req_x[i*W +: W] = x_op[i];
      req_y[i*W +: W] = y_op[i];
    end
  endtask

  function automatic int oh2i(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Check the grant presented this cycle; queue the result it must produce.
  task automatic step(input logic [NR-1:0] exp_ready);
    exp_t t;
    int   w;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (exp_ready != '0) begin
      w     = oh2i(exp_ready);
      t.due = cyc + 2;
      t.id  = 2'(w);
      t.z   = x_op[w] & y_op[w];
      q.push_back(t);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    for (int i = 0; i < 3; i++) step('0);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every response must match the head of the queue on its due cycle.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id %0d z %h, expected no response", rsp_id, rsp_z);
      end else begin
        e = q.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_z", rsp_z, e.z);
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_rsp: got no response, expected id %0d z %h at cycle %0d", e.id, e.z, e.due);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      x_op[i] = '0;
      y_op[i] = '0;
    end
    drive_ops();
    #1 rst = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_z", rsp_z, 32'd0);
    chk("reset_gcount", 32'(grant_count), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Single requester: 0xF0F0F0F0 & 0xFF00FF00 = 0xF000F000, tag 1
    x_op[1] = 32'hF0F0_F0F0;
    y_op[1] = 32'hFF00_FF00;
    drive_ops();
    req_valid = 4'b0010;
    step(4'b0010);
    chk("single_gcount", 32'(grant_count), 32'd1);
    drain();

    // Full contention: rotation 0,1,2,3,0,1,2,3 with fresh operands per grant
    do_reset();
    for (int i = 0; i < NR; i++) begin
      x_op[i] = 32'h1111_1111 * (i + 1);
      y_op[i] = 32'hF0F0_0FF0 ^ (32'h0101_0101 << i);
    end
    drive_ops();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step(4'b0001 << (k % NR));
      x_op[k % NR] = {8'(k), 8'(k % NR), 16'hBEEF};
      y_op[k % NR] = 32'h0FF0_F0F0 ^ 32'(k * 7);
      drive_ops();
    end
    chk("contention_gcount", 32'(grant_count), 32'd8);
    drain();

    // Partial contention: 1 and 3 alternate
    do_reset();
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) step((k % 2 == 0) ? 4'b0010 : 4'b1000);
    drain();

    // Enable dropped after two grants; in-flight results still emerge
    do_reset();
    req_valid = 4'b1111;
    step(4'b0001);
    step(4'b0010);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) step('0);
    enable = 1'b1;
    step(4'b0100);
    step(4'b1000);
    chk("enable_gcount", 32'(grant_count), 32'd4);
    drain();

    // Reset while a result is in flight; pointer returns to 0
    do_reset();
    req_valid = 4'b0010;
    step(4'b0010);
    req_valid = 4'b1010;
    rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_id", 32'(rsp_id), 32'd0);
    chk("midrst_rsp_z", rsp_z, 32'd0);
    chk("midrst_gcount", 32'(grant_count), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(4'b0010);
    drain();

    // Grant counter wrap with a single requester every cycle
    do_reset();
    x_op[0] = 32'hDEAD_BEEF;
    y_op[0] = 32'h0F0F_FFFF;
    drive_ops();
    req_valid = 4'b0001;
    for (int k = 1; k <= 65537; k++) begin
      step(4'b0001);
      if (k == 65535) chk("gcount_ffff", 32'(grant_count), 32'h0000_FFFF);
    end
    chk("gcount_wrap", 32'(grant_count), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_and_share_sched
`default_nettype wire
